// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered 16-op ALU with NZCV flags, valid/ready issue and iterative multiply
// Single-cycle ops complete on the accept edge; MUL runs one shift-add step per cycle for W cycles.
module alu_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic         set_flags,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int SHW = $clog2(W);
  localparam logic [SHW:0]   W_S   = (SHW+1)'(W);
  localparam logic [SHW-1:0] W_LOW = SHW'(W);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_RSB = 4'd2;
  localparam logic [3:0] OP_BIC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_ORR = 4'd5;
  localparam logic [3:0] OP_EOR = 4'd6;
  localparam logic [3:0] OP_XNR = 4'd7;
  localparam logic [3:0] OP_ADC = 4'd8;
  localparam logic [3:0] OP_SBC = 4'd9;
  localparam logic [3:0] OP_LSL = 4'd10;
  localparam logic [3:0] OP_LSR = 4'd11;
  localparam logic [3:0] OP_ASR = 4'd12;
  localparam logic [3:0] OP_ROR = 4'd13;
  localparam logic [3:0] OP_MUL = 4'd14;
  localparam logic [3:0] OP_MOV = 4'd15;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t       state_q, state_d;
  logic [SHW:0] cnt_q, cnt_d;
  logic [W-1:0] ma_q, ma_d, mb_q, mb_d, acc_q, acc_d;
  logic         sf_q, sf_d;
  logic [W-1:0] result_q, result_d;
  logic [3:0]   flags_q, flags_d;
  logic         out_valid_q, out_valid_d;

  // Shared adder: every arithmetic op is x + y + cin in W+1 bits.
  logic [W-1:0] add_x, add_y;
  logic         add_cin;
  logic [W:0]   sum;
  logic         add_v;

  always_comb begin
    add_x   = a;
    add_y   = b;
    add_cin = 1'b0;
    case (op)
      OP_SUB: begin add_y = ~b; add_cin = 1'b1; end
      OP_RSB: begin add_x = b; add_y = ~a; add_cin = 1'b1; end
      OP_ADC: add_cin = flags_q[1];
      OP_SBC: begin add_y = ~b; add_cin = flags_q[1]; end
      default: ;
    endcase
  end

  assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};
  assign add_v = (add_x[W-1] == add_y[W-1]) & (sum[W-1] != add_x[W-1]);

  // Shift amount reduced modulo W; only non-power-of-two widths ever need the subtract.
  logic         s_ge;
  logic [SHW-1:0] s;
  logic [W:0]   lsl_w, lsr_w, asr_w;
  logic [W-1:0] ror_r;

  assign s_ge  = {1'b0, b[SHW-1:0]} >= W_S;
  assign s     = s_ge ? (b[SHW-1:0] - W_LOW) : b[SHW-1:0];
  assign lsl_w = {1'b0, a} << s;
  assign lsr_w = {a, 1'b0} >> s;
  assign asr_w = $signed({a, 1'b0}) >>> s;
  assign ror_r = (a >> s) | (a << (W_S - {1'b0, s}));

  logic [W-1:0] alu_r;
  logic         alu_c, alu_v, alu_wr_c, alu_wr_v;

  always_comb begin
    alu_r    = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_wr_c = 1'b0;
    alu_wr_v = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_RSB, OP_ADC, OP_SBC: begin
        alu_r    = sum[W-1:0];
        alu_c    = sum[W];
        alu_v    = add_v;
        alu_wr_c = 1'b1;
        alu_wr_v = 1'b1;
      end
      OP_BIC: alu_r = a & ~b;
      OP_AND: alu_r = a & b;
      OP_ORR: alu_r = a | b;
      OP_EOR: alu_r = a ^ b;
      OP_XNR: alu_r = ~(a ^ b);
      OP_LSL: begin alu_r = lsl_w[W-1:0]; alu_c = lsl_w[W]; alu_wr_c = (s != '0); end
      OP_LSR: begin alu_r = lsr_w[W:1];   alu_c = lsr_w[0]; alu_wr_c = (s != '0); end
      OP_ASR: begin alu_r = asr_w[W:1];   alu_c = asr_w[0]; alu_wr_c = (s != '0); end
      OP_ROR: begin alu_r = ror_r;        alu_c = ror_r[W-1]; alu_wr_c = (s != '0); end
      OP_MOV: alu_r = b;
      default: ;
    endcase
  end

  logic [W-1:0] mul_sum;
  assign mul_sum = acc_q + (mb_q[0] ? ma_q : '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    acc_d       = acc_q;
    sf_d        = sf_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            ma_d    = a;
            mb_d    = b;
            sf_d    = set_flags;
            acc_d   = '0;
            cnt_d   = W_S;
            state_d = S_MUL;
          end else begin
            result_d    = alu_r;
            out_valid_d = 1'b1;
            if (set_flags) begin
              flags_d = {alu_r[W-1], alu_r == '0,
                         alu_wr_c ? alu_c : flags_q[1],
                         alu_wr_v ? alu_v : flags_q[0]};
            end
          end
        end
      end
      S_MUL: begin
        acc_d = mul_sum;
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == (SHW+1)'(1)) begin
          result_d    = mul_sum;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
          if (sf_q) flags_d = {mul_sum[W-1], mul_sum == '0, flags_q[1:0]};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      acc_q       <= '0;
      sf_q        <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      acc_q       <= acc_d;
      sf_q        <= sf_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed and random checks of alu_seq at W=8 and W=32 against an arithmetic model
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_ready, set_flags, out_valid;
  logic [3:0] op, flags;
  logic [7:0] a, b, result;

  logic        in_valid32, in_ready32, set_flags32, out_valid32;
  logic [3:0]  op32, flags32;
  logic [31:0] a32, b32, result32;

  alu_seq #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .set_flags(set_flags), .a(a), .b(b), .out_valid(out_valid), .result(result), .flags(flags)
  );

  alu_seq #(.W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32), .op(op32),
    .set_flags(set_flags32), .a(a32), .b(b32), .out_valid(out_valid32), .result(result32),
    .flags(flags32)
  );

  int total = 0;
  int bad   = 0;
  logic [3:0]  mflags8, mflags32;
  logic [7:0]  mres8;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Integer reference: results from plain arithmetic, C/V from range tests.
  function automatic void model(input int w, input int o, input logic [63:0] a_in,
                                input logic [63:0] b_in, input logic [3:0] fl, input logic sf,
                                output logic [63:0] r, output logic [3:0] nf);
    longint full = longint'(1) << w;
    longint half = full >> 1;
    longint x = longint'(a_in);
    longint y = longint'(b_in);
    longint sx = (x >= half) ? x - full : x;
    longint sy = (y >= half) ? y - full : y;
    longint cin = longint'(fl[1]);
    longint t = 0, st = 0;
    logic c = fl[1], v = fl[0];
    bit arith = 1'b0;
    int s = int'(y % w);
    case (o)
      0:  begin t = x + y;           st = sx + sy;           c = (t >= full); arith = 1; end
      1:  begin t = x - y;           st = sx - sy;           c = (t >= 0);    arith = 1; end
      2:  begin t = y - x;           st = sy - sx;           c = (t >= 0);    arith = 1; end
      8:  begin t = x + y + cin;     st = sx + sy + cin;     c = (t >= full); arith = 1; end
      9:  begin t = x - y - 1 + cin; st = sx - sy - 1 + cin; c = (t >= 0);    arith = 1; end
      3:  t = x & ~y;
      4:  t = x & y;
      5:  t = x | y;
      6:  t = x ^ y;
      7:  t = ~(x ^ y);
      10: begin t = x << s;  if (s != 0) c = ((x >> (w - s)) & 1) != 0; end
      11: begin t = x >> s;  if (s != 0) c = ((x >> (s - 1)) & 1) != 0; end
      12: begin t = sx >>> s; if (s != 0) c = ((x >> (s - 1)) & 1) != 0; end
      13: begin t = (x >> s) | (x << (w - s)); if (s != 0) c = ((x >> (s - 1)) & 1) != 0; end
      14: t = x * y;
      default: t = y;
    endcase
    if (arith) v = (st < -half) || (st >= half);
    r  = 64'(t & (full - 1));
    nf = sf ? {r[w-1], r == 0, c, v} : fl;
  endfunction

  task automatic issue8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic sf);
    logic [63:0] r;
    logic [3:0]  nf;
    int n;
    model(8, int'(o), 64'(x), 64'(y), mflags8, sf, r, nf);
    @(negedge clk);
    op = o; a = x; b = y; set_flags = sf; in_valid = 1'b1;
    chk("in_ready_idle", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    if (o == 4'd14) begin
      op = 4'd0;  // keep requesting an ADD; it must not be taken while multiplying
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
        chk("mul_busy_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        n++;
      end
      chk("mul_latency", 64'(n), 64'(8));
    end
    in_valid = 1'b0;
    chk("out_valid", 64'(out_valid), 64'(1));
    chk("result", 64'(result), r);
    chk("flags", 64'(flags), 64'(nf));
    mres8   = r[7:0];
    mflags8 = nf;
  endtask

  task automatic idle8();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_out_valid", 64'(out_valid), 64'(0));
    chk("idle_result", 64'(result), 64'(mres8));
    chk("idle_flags", 64'(flags), 64'(mflags8));
  endtask

  task automatic issue32(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    logic [3:0]  nf;
    model(32, int'(o), 64'(x), 64'(y), mflags32, 1'b1, r, nf);
    @(negedge clk);
    op32 = o; a32 = x; b32 = y; set_flags32 = 1'b1; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    chk("w32_out_valid", 64'(out_valid32), 64'(1));
    chk("w32_result", 64'(result32), r);
    chk("w32_flags", 64'(flags32), 64'(nf));
    mflags32 = nf;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    rst_n = 1'b0;
    in_valid = 1'b0; op = '0; a = '0; b = '0; set_flags = 1'b0;
    in_valid32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; set_flags32 = 1'b0;
    mflags8 = '0; mflags32 = '0; mres8 = '0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_flags", 64'(flags), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    idle8();

    issue8(4'd0, 8'h7F, 8'h01, 1'b1);
    chk("add7f_res", 64'(result), 64'h80);
    chk("add7f_flags", 64'(flags), 64'(4'b1001));
    issue8(4'd1, 8'h05, 8'h05, 1'b1);
    chk("sub05_flags", 64'(flags), 64'(4'b0110));
    issue8(4'd8, 8'h01, 8'h01, 1'b1);
    chk("adc_res", 64'(result), 64'h03);
    issue8(4'd1, 8'h05, 8'h05, 1'b1);
    issue8(4'd14, 8'h0F, 8'h11, 1'b1);
    chk("mul_res", 64'(result), 64'hFF);
    chk("mul_flags", 64'(flags), 64'(4'b1010));
    idle8();
    issue8(4'd11, 8'h81, 8'h01, 1'b1);
    chk("lsr_res", 64'(result), 64'h40);
    chk("lsr_flags", 64'(flags), 64'(4'b0010));
    issue8(4'd13, 8'h01, 8'h01, 1'b1);
    chk("ror_res", 64'(result), 64'h80);
    chk("ror_flags", 64'(flags), 64'(4'b1010));
    issue8(4'd10, 8'h81, 8'h00, 1'b1);
    chk("lsl0_res", 64'(result), 64'h81);
    chk("lsl0_flags", 64'(flags), 64'(4'b1010));
    issue8(4'd0, 8'h7F, 8'h01, 1'b1);
    issue8(4'd4, 8'hFF, 8'h00, 1'b0);
    chk("and_nosf_flags", 64'(flags), 64'(4'b1001));
    issue8(4'd4, 8'hFF, 8'h00, 1'b1);
    chk("and_sf_flags", 64'(flags), 64'(4'b0101));
    idle8();

    for (int i = 0; i < 160; i++) begin
      issue8(4'($urandom_range(15, 0)), 8'($urandom), 8'($urandom), 1'($urandom_range(1, 0)));
      if (i % 16 == 15) idle8();
    end

    // Reset in the middle of a multiply.
    @(negedge clk);
    op = 4'd14; a = 8'h0F; b = 8'h11; set_flags = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midmul_rst_out_valid", 64'(out_valid), 64'(0));
    chk("midmul_rst_result", 64'(result), 64'(0));
    chk("midmul_rst_flags", 64'(flags), 64'(0));
    chk("midmul_rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk); rst_n = 1'b1;
    mflags8 = '0; mres8 = '0; mflags32 = '0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
    end
    chk("midmul_no_pulse", 64'(pulses), 64'(0));
    chk("midmul_after_ready", 64'(in_ready), 64'(1));

    issue32(4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("w32_add_ovf_flags", 64'(flags32), 64'(4'b1001));
    issue32(4'd1, 32'h8000_0000, 32'h0000_0001);
    chk("w32_sub_ovf_res", 64'(result32), 64'h7FFF_FFFF);
    chk("w32_sub_ovf_flags", 64'(flags32), 64'(4'b0011));
    issue32(4'd0, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("w32_add_carry_flags", 64'(flags32), 64'(4'b0110));
    issue32(4'd1, 32'h0000_0000, 32'h0000_0001);
    chk("w32_sub_borrow_flags", 64'(flags32), 64'(4'b1000));
    issue32(4'd2, 32'h0000_0001, 32'h8000_0000);
    for (int i = 0; i < 20; i++) issue32(4'($urandom_range(2, 0)), $urandom, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
